// File: rtl/seg_capture_decode.sv
// Monitors a multiplexed seven-segment bus and rebuilds the displayed digits.
// A digit is accepted after a stable dwell, and full frames are published with a one-cycle strobe.
module seg_capture_decode #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS-1:0]     dig_sel,
    input  logic [6:0]            seg,
    input  logic                  dp,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     dp_out,
    output logic [DIGITS-1:0]     blank,
    output logic                  frame_valid,
    output logic                  frame_err
);

    localparam logic [1:0] ST_WAIT_SEL = 2'd0;
    localparam logic [1:0] ST_DWELL    = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;
    localparam logic [7:0] CNT_TARGET  = 8'(STABLE_CYCLES);

    logic [DIGITS-1:0]   sel_p0, sel_p1;
    logic [6:0]          seg_p0, seg_p1;
    logic                dp_p0, dp_p1;
    logic [7:0]          cnt_p1;
    logic [1:0]          state;
    logic                differ;
    logic                vld_p1;
    logic [DIGITS-1:0]   cap_bits;
    logic [5:0]          dec_p1;
    logic [DIGITS-1:0]   mask;
    logic                frame_done;
    logic [4*DIGITS-1:0] sh_val;
    logic [DIGITS-1:0]   sh_dp, sh_blank, sh_inv;

    function automatic logic is_onehot(input logic [DIGITS-1:0] s);
        return (s != '0) && ((s & (s - 1'b1)) == '0);
    endfunction

    // Result packs {invalid, blank, nibble}.
    function automatic logic [5:0] seg_decode(input logic [6:0] s);
        case (s)
            7'h3F:   return 6'b00_0000;
            7'h06:   return 6'b00_0001;
            7'h5B:   return 6'b00_0010;
            7'h4F:   return 6'b00_0011;
            7'h66:   return 6'b00_0100;
            7'h6D:   return 6'b00_0101;
            7'h7D:   return 6'b00_0110;
            7'h07:   return 6'b00_0111;
            7'h7F:   return 6'b00_1000;
            7'h6F:   return 6'b00_1001;
            7'h00:   return 6'b01_0000;
            default: return 6'b10_1111;
        endcase
    endfunction

    assign differ     = (sel_p0 != sel_p1) || (seg_p0 != seg_p1) || (dp_p0 != dp_p1);
    assign vld_p1     = (state == ST_DWELL) && (cnt_p1 == CNT_TARGET);
    assign cap_bits   = vld_p1 ? sel_p1 : '0;
    assign dec_p1     = seg_decode(seg_p1);
    assign frame_done = &mask;

    // p0: input sample; p1: held copy with dwell tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_p0 <= '0;
            seg_p0 <= '0;
            dp_p0  <= 1'b0;
            sel_p1 <= '0;
            seg_p1 <= '0;
            dp_p1  <= 1'b0;
            cnt_p1 <= '0;
            state  <= ST_WAIT_SEL;
        end else begin
            sel_p0 <= dig_sel;
            seg_p0 <= seg;
            dp_p0  <= dp;
            if (differ) begin
                sel_p1 <= sel_p0;
                seg_p1 <= seg_p0;
                dp_p1  <= dp_p0;
                cnt_p1 <= 8'd1;
                state  <= is_onehot(sel_p0) ? ST_DWELL : ST_WAIT_SEL;
            end else if (state == ST_DWELL) begin
                if (cnt_p1 == CNT_TARGET)
                    state <= ST_HELD;
                else
                    cnt_p1 <= cnt_p1 + 8'd1;
            end
        end
    end

    // p2: shadow slots, written on capture
    always_ff @(posedge clk) begin
        for (int i = 0; i < DIGITS; i++) begin
            if (cap_bits[i]) begin
                sh_val[4*i +: 4] <= dec_p1[3:0];
                sh_blank[i]      <= dec_p1[4];
                sh_dp[i]         <= dp_p1;
            end
        end
    end

    // A capture landing on the frame-copy edge seeds the next frame's mask.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask        <= '0;
            sh_inv      <= '0;
            value       <= '0;
            dp_out      <= '0;
            blank       <= '1;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= frame_done;
            mask        <= (frame_done ? '0 : mask) | cap_bits;
            for (int i = 0; i < DIGITS; i++) begin
                if (cap_bits[i])
                    sh_inv[i] <= dec_p1[5];
                else if (frame_done)
                    sh_inv[i] <= 1'b0;
            end
            if (frame_done) begin
                value     <= sh_val;
                dp_out    <= sh_dp;
                blank     <= sh_blank;
                frame_err <= |sh_inv;
            end
        end
    end

endmodule

// File: tb/tb_seg_capture_decode.sv
// Directed bench for seg_capture_decode: a STABLE_CYCLES=4 instance and a STABLE_CYCLES=1 instance.
module tb_seg_capture_decode;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  dig_sel = '0;
    logic [6:0]  seg = '0;
    logic        dp = 1'b0;

    logic [15:0] value, value1;
    logic [3:0]  dp_out, dp_out1, blank, blank1;
    logic        frame_valid, frame_valid1, frame_err, frame_err1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fv_cnt   = 0;
    int fv1_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (frame_valid) fv_cnt++;
        if (frame_valid1) fv1_q.push_back(cyc);
    end

    seg_capture_decode #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .dig_sel(dig_sel), .seg(seg), .dp(dp),
        .value(value), .dp_out(dp_out), .blank(blank),
        .frame_valid(frame_valid), .frame_err(frame_err)
    );

    seg_capture_decode #(.DIGITS(4), .STABLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .dig_sel(dig_sel), .seg(seg), .dp(dp),
        .value(value1), .dp_out(dp_out1), .blank(blank1),
        .frame_valid(frame_valid1), .frame_err(frame_err1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic dwell(input int slot, input logic [6:0] s, input logic d, input int n);
        dig_sel = 4'b0001 << slot;
        seg     = s;
        dp      = d;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [3:0] sel, input int n);
        dig_sel = sel;
        seg     = 7'h7F;
        dp      = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan4(input int n);
        dwell(3, 7'h06, 1'b0, n);
        dwell(2, 7'h5B, 1'b0, n);
        dwell(1, 7'h4F, 1'b0, n);
        dwell(0, 7'h66, 1'b0, n);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        dig_sel = '0;
        seg     = '0;
        dp      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_value"}, value, 16'h0000);
        chk({tag, "_blank"}, blank, 4'hF);
        chk({tag, "_dp"}, dp_out, 4'h0);
        chk({tag, "_fv"}, frame_valid, 1'b0);
        chk({tag, "_err"}, frame_err, 1'b0);
    endtask

    int base;
    int c0;

    initial begin
        // Reset state and a basic frame
        do_reset();
        chk_reset_outputs("rst0");
        base = fv_cnt;
        dwell(3, 7'h06, 1'b0, 8);
        dwell(2, 7'h5B, 1'b0, 8);
        dwell(1, 7'h4F, 1'b0, 8);
        chk("partial_no_update", value, 16'h0000);
        dwell(0, 7'h66, 1'b0, 8);
        idle(4'b0000, 4);
        chk("t1_frames", fv_cnt - base, 1);
        chk("t1_value", value, 16'h1234);
        chk("t1_blank", blank, 4'h0);
        chk("t1_dp", dp_out, 4'h0);
        chk("t1_err", frame_err, 1'b0);

        // Short dwell on slot 2 is ignored until the second pass
        base = fv_cnt;
        dwell(3, 7'h06, 1'b0, 8);
        dwell(2, 7'h5B, 1'b0, 2);
        dwell(1, 7'h4F, 1'b0, 8);
        dwell(0, 7'h66, 1'b0, 8);
        idle(4'b0000, 4);
        chk("t2_no_frame_first_pass", fv_cnt - base, 0);
        scan4(8);
        idle(4'b0000, 4);
        chk("t2_frames", fv_cnt - base, 1);
        chk("t2_value", value, 16'h1234);

        // Invalid pattern, blank digit with decimal point
        do_reset();
        base = fv_cnt;
        dwell(3, 7'h06, 1'b0, 8);
        dwell(2, 7'h5B, 1'b0, 8);
        dwell(1, 7'h49, 1'b0, 8);
        dwell(0, 7'h00, 1'b1, 8);
        idle(4'b0000, 4);
        chk("t3_frames", fv_cnt - base, 1);
        chk("t3_value", value, 16'h12F0);
        chk("t3_err", frame_err, 1'b1);
        chk("t3_blank", blank, 4'b0001);
        chk("t3_dp", dp_out, 4'b0001);
        idle(4'b0000, 10);
        chk("t3_err_held", frame_err, 1'b1);

        // Zero and multi-hot selects between valid dwells
        base = fv_cnt;
        dwell(3, 7'h7D, 1'b0, 8);
        idle(4'b0000, 20);
        dwell(2, 7'h07, 1'b0, 8);
        idle(4'b0110, 20);
        dwell(1, 7'h7F, 1'b0, 8);
        chk("t4_no_early_frame", fv_cnt - base, 0);
        dwell(0, 7'h6F, 1'b0, 8);
        idle(4'b0000, 4);
        chk("t4_frames", fv_cnt - base, 1);
        chk("t4_value", value, 16'h6789);
        chk("t4_err_cleared", frame_err, 1'b0);
        chk("t4_blank", blank, 4'h0);

        // STABLE_CYCLES=1, continuous 2-cycle dwell scan
        do_reset();
        fv1_q.delete();
        c0 = cyc;
        for (int p = 0; p < 3; p++) scan4(2);
        idle(4'b0000, 6);
        chk("t5_frames", fv1_q.size(), 3);
        if (fv1_q.size() >= 3) begin
            chk("t5_first_latency", fv1_q[0] - c0, 10);
            chk("t5_period_a", fv1_q[1] - fv1_q[0], 8);
            chk("t5_period_b", fv1_q[2] - fv1_q[1], 8);
        end
        chk("t5_value", value1, 16'h1234);
        chk("t5_err", frame_err1, 1'b0);

        // Reset mid-frame discards partial captures
        do_reset();
        chk_reset_outputs("rst1");
        scan4(8);
        idle(4'b0000, 4);
        chk("t6_pre_value", value, 16'h1234);
        dwell(3, 7'h7F, 1'b0, 8);
        dwell(2, 7'h7F, 1'b0, 8);
        dwell(1, 7'h7F, 1'b0, 8);
        rst     = 1'b1;
        dig_sel = '0;
        seg     = '0;
        #1;
        chk_reset_outputs("rst_mid");
        @(posedge clk);
        #1;
        rst  = 1'b0;
        base = fv_cnt;
        dwell(0, 7'h66, 1'b0, 8);
        idle(4'b0000, 6);
        chk("t6_no_frame_after_rst", fv_cnt - base, 0);
        dwell(3, 7'h06, 1'b0, 8);
        dwell(2, 7'h5B, 1'b0, 8);
        dwell(1, 7'h4F, 1'b0, 8);
        idle(4'b0000, 6);
        chk("t6_frames", fv_cnt - base, 1);
        chk("t6_value", value, 16'h1234);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_capture_decode.md
# seg_capture_decode

Receive-side counterpart of the segment decoder. Samples a multiplexed, active-high seven-segment bus (one-hot digit select, segments, decimal point) and recovers the displayed digits. It validates each digit over a dwell window and decodes segment patterns back to 4-bit values. A complete multi-digit frame is published with a one-cycle strobe. Used as an on-chip monitor and loopback checker on the display path of the RPM counter.

## Interface
- DIGITS, 4, number of multiplexed digit positions (≥1)
- STABLE_CYCLES, 4, consecutive identical samples needed to accept a digit (≥1, ≤255)

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- dig_sel  in  DIGITS  one-hot digit enable; bit i selects slot i
- seg  in  7  active-high segments, seg[0]=a … seg[6]=g
- dp  in  1  decimal point for the selected digit
- value  out  4*DIGITS  decoded digits, slot i at [4i+3:4i]
- dp_out  out  DIGITS  captured decimal point per slot
- blank  out  DIGITS  slot showed all segments off
- frame_valid  out  1  one-cycle pulse, new frame on outputs
- frame_err  out  1  frame contained ≥1 unrecognised pattern, valid with frame_valid, held until next frame

## Operation
- Input stage: {dig_sel, seg, dp} registered once into sync regs every cycle (no metastability chain; inputs are synchronous).
- Dwell tracker, per cycle, comparing sync regs against held regs:
  - differ: held ← sync, count ← 1, state → DWELL if held dig_sel is one-hot, else WAIT_SEL.
  - equal, DWELL: count increments. When count reaches STABLE_CYCLES, issue capture for the selected slot and state → HELD.
  - equal, HELD or WAIT_SEL: no action; count saturates. One capture per dwell, regardless of dwell length.
- dig_sel all-zero or multi-hot: WAIT_SEL, never captured.
- Decode table (seg hex → nibble): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9. 00→nibble 0 with blank=1. Any other pattern → nibble F and invalid flag.
- Capture writes slot i of shadow registers (nibble, dp, blank, invalid) and sets mask bit i. Recapturing a slot already in the mask overwrites it with the newer data.
- Frame completion: when mask becomes all-ones, the next edge:
  - copies the shadow to the outputs,
  - sets frame_err = OR of the invalid flags,
  - pulses frame_valid,
  - clears the mask and invalid flags.
- A capture in the same cycle as the frame copy belongs to the next frame.
- Outputs change only at frame completion.

## Timing
- Reset values:
  - value=0, dp_out=0, blank=all-ones, frame_valid=0, frame_err=0.
  - mask=0, count=0, held regs=0, state WAIT_SEL.
- Asserting rst mid-frame discards partial captures. The first post-reset frame needs all DIGITS slots captured afresh.
- Latency, with inputs steady from before edge 0: sync at edge 0, count=1 at edge 1, count=STABLE_CYCLES at edge STABLE_CYCLES. Shadow written at edge STABLE_CYCLES+1.
- If that capture completes the mask, outputs update and frame_valid is high from edge STABLE_CYCLES+2 for exactly one cycle.
- An input change lasting fewer than STABLE_CYCLES cycles produces no capture.
- Minimum scan dwell for reliable capture: STABLE_CYCLES+1 cycles per digit.
- Back-to-back frames are supported. frame_valid may pulse on consecutive frame boundaries with no dead cycle beyond the dwell requirement.

## Test plan
- Reset then scan slots 3..0 with patterns 06,5B,4F,66 (no dp), 8 cycles each → one frame_valid, value=16'h1234, blank=0, dp_out=0, frame_err=0.
- Same scan, but slot 2 held for only 2 cycles on the first pass and captured on the second → frame_valid only after the second pass, value=16'h1234. No pulse is produced on the first pass.
- Slot 1 pattern 49 (invalid), slot 0 pattern 00 with dp=1, others valid → value[7:4]=F, frame_err=1, blank[0]=1, value[3:0]=0, dp_out[0]=1.
- dig_sel=4'b0000 and 4'b0110 for 20 cycles each between valid dwells → no capture, mask unaffected, frame completes only on the valid dwells.
- STABLE_CYCLES=1, dwell 2 cycles per digit, continuous scan → frame_valid every 2*DIGITS cycles with correct data; latency from first edge = 3 edges.
- Assert rst after 3 of 4 slots captured → outputs return to reset values immediately. The next frame_valid occurs only after 4 new captures.
